riscv_stall_ctrl: RTL and testbench
===================================

Name: riscv_stall_ctrl

Overview:
- Central pipeline hazard controller; the single producer of the 5-bit stall vector consumed by every stage register: PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Collects stall requests from the IF, ID, EX and MEM stages and the branch-taken signal from EX.
- Drives the stall vector and a flush strobe for IF/ID and ID/EX.
- Holds a pending-flush state, a stall-run watchdog and performance counters.

Parameters:
MAX_STALL, 1024, consecutive stalled cycles at which timeout_o sets (>=2)
CNT_W, 32, width of stall-cycle counter

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  asynchronous, active-low reset
stallreq_if_i  in  1  fetch not ready (imem wait)
stallreq_id_i  in  1  load-use hazard detected in decode
stallreq_ex_i  in  1  multi-cycle EX op busy
stallreq_mem_i  in  1  dmem not ready
br_taken_i  in  1  branch/jump resolved taken in EX this cycle
clr_i  in  1  synchronous clear of counters and timeout flag
stall_o  out  5  stall vector; bit k holds stage register k; bit0=PC, bit4=MEM/WB
flush_o  out  1  kill IF/ID and ID/EX contents this cycle
stall_cnt_o  out  CNT_W  cycles with stall_o != 0
flush_cnt_o  out  16  number of flushes issued
timeout_o  out  1  sticky: stall run reached MAX_STALL

Behaviour:
- Stage-register contract: a stage register holds when stall[k]=1. It loads a bubble when stall[k]=1 and stall[k+1]=0.
- stall_o is combinational from the current inputs and flush_pend. Evaluate in priority order:
  - stallreq_mem_i=1 -> 5'b01111.
  - else stallreq_ex_i=1 -> 5'b00111.
  - else flush_now=1 -> 5'b00000. IF and ID requests are ignored because those instructions are being killed.
  - else stallreq_id_i=1 -> 5'b00011.
  - else stallreq_if_i=1 -> 5'b00001.
  - else 5'b00000.
- ex_adv = ~stall_o[2]. Compute from the mem/ex terms only, so the logic has no loop.
- flush_now = ex_adv & (br_taken_i | flush_pend). flush_o = flush_now. flush_o is combinational.
- flush_pend register, reset 0:
  - Set when br_taken_i=1 and ex_adv=0.
  - Cleared when flush_now=1.
  - Set and clear in the same cycle is impossible by construction.
- Exactly one flush_o pulse per taken branch, even when br_taken_i stays high across held EX cycles. The pending flag absorbs the repeat: when flush_pend=1, br_taken_i is ignored for setting.
- run counter, internal, width clog2(MAX_STALL)+1, reset 0:
  - Increments when stall_o != 0.
  - Clears to 0 when stall_o == 0.
  - Saturates at MAX_STALL.
- timeout_o sets on the clock edge where run transitions to MAX_STALL. It stays set until clr_i or reset.
- stall_cnt_o increments by 1 when stall_o != 0 and wraps modulo 2^CNT_W.
- flush_cnt_o increments on flush_now and wraps modulo 2^16.
- clr_i=1 zeros stall_cnt_o, flush_cnt_o and timeout_o next edge. clr_i wins over a simultaneous increment or timeout set. clr_i does not affect run, flush_pend, stall_o or flush_o.
- Reset, asynchronous on rst=0:
  - flush_pend=0, run=0, stall_cnt_o=0, flush_cnt_o=0, timeout_o=0.
  - stall_o and flush_o then follow the inputs combinationally.
  - A reset mid-stall or with a pending flush discards the pending flush.
- Latency: stall_o and flush_o have zero cycles of latency from their requests. A deferred flush fires in the first cycle EX advances.

Test Plan:
- Each request alone for 1 cycle (if, id, ex, mem) -> stall_o = 00001, 00011, 00111, 01111 respectively. stall_cnt_o increments by 1 each time. flush_o=0.
- stallreq_id_i=1 and br_taken_i=1 in the same cycle -> stall_o=00000, flush_o=1, flush_cnt_o increments by 1.
- br_taken_i=1 held for 4 cycles, stallreq_mem_i=1 for cycles 0-2 -> flush_o=0 in cycles 0-2, flush_o=1 only in cycle 3, flush_cnt_o increments by exactly 1.
- MAX_STALL=8, stallreq_ex_i held 10 cycles -> timeout_o rises after the 8th stalled edge and stays 1 after the request drops. A later clr_i pulse returns timeout_o and both counters to 0.
- Assert rst=0 while flush_pend=1 and mid-stall, then release with no requests -> all counters 0, timeout_o=0, and no flush_o pulse afterwards.
- stall_cnt_o preloaded via a 2^CNT_W-1 stalled-cycle run (use CNT_W=4 in a bench build), one more stalled cycle -> stall_cnt_o wraps to 0.

Source files
------------

// File: rtl/riscv_stall_ctrl_if.sv
// rtl/riscv_stall_ctrl_if.sv - stall controller request/response bundle
interface riscv_stall_ctrl_if #(
    parameter int CNT_W = 32
);
    // stage stall requests and branch resolution
    logic             stallreq_if_i;
    logic             stallreq_id_i;
    logic             stallreq_ex_i;
    logic             stallreq_mem_i;
    logic             br_taken_i;
    logic             clr_i;

    // pipeline control and statistics
    logic [4:0]       stall_o;
    logic             flush_o;
    logic [CNT_W-1:0] stall_cnt_o;
    logic [15:0]      flush_cnt_o;
    logic             timeout_o;

    // pipeline side: raises requests, consumes stall/flush
    modport master (
        output stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        output br_taken_i, clr_i,
        input  stall_o, flush_o, stall_cnt_o, flush_cnt_o, timeout_o
    );

    // controller side
    modport slave (
        input  stallreq_if_i, stallreq_id_i, stallreq_ex_i, stallreq_mem_i,
        input  br_taken_i, clr_i,
        output stall_o, flush_o, stall_cnt_o, flush_cnt_o, timeout_o
    );
endinterface

// File: rtl/riscv_stall_ctrl.sv
// rtl/riscv_stall_ctrl.sv - central pipeline stall/flush controller
module riscv_stall_ctrl #(
    parameter int MAX_STALL = 1024,
    parameter int CNT_W     = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    riscv_stall_ctrl_if.slave      bus
);
    localparam int                 RUN_W   = $clog2(MAX_STALL) + 1;
    localparam logic [RUN_W-1:0]   RUN_MAX = RUN_W'(MAX_STALL);
    localparam logic [RUN_W-1:0]   RUN_PRE = RUN_W'(MAX_STALL - 1);

    logic [4:0]       w_stall;
    logic             w_stalled;
    logic             w_ex_adv;
    logic             w_flush_now;
    logic             w_run_hit;

    logic             r_flush_pend;
    logic [RUN_W-1:0] r_run;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [15:0]      r_flush_cnt;
    logic             r_timeout;

    // EX advances unless MEM or EX itself holds it; kept off the flush path
    // so the stall vector and the flush decision do not form a loop
    assign w_ex_adv    = ~(bus.stallreq_mem_i | bus.stallreq_ex_i);

    // a taken branch (now or deferred) kills IF/ID and ID/EX once EX moves
    assign w_flush_now = w_ex_adv & (bus.br_taken_i | r_flush_pend);

    // prioritized stall vector: deeper stages win, flush overrides IF/ID holds
    always_comb begin
        w_stall = 5'b00000;
        if (bus.stallreq_mem_i) begin
            w_stall = 5'b01111;
        end else if (bus.stallreq_ex_i) begin
            w_stall = 5'b00111;
        end else if (w_flush_now) begin
            w_stall = 5'b00000;
        end else if (bus.stallreq_id_i) begin
            w_stall = 5'b00011;
        end else if (bus.stallreq_if_i) begin
            w_stall = 5'b00001;
        end
    end

    assign w_stalled = |w_stall;

    // run reaching MAX_STALL on this edge
    assign w_run_hit = w_stalled & (r_run == RUN_PRE);

    // pending flush: remembers a taken branch while EX is held; while set,
    // a repeated br_taken_i is absorbed so only one flush is issued
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_pend <= 1'b0;
        end else if (w_flush_now) begin
            r_flush_pend <= 1'b0;
        end else if (bus.br_taken_i && !w_ex_adv) begin
            r_flush_pend <= 1'b1;
        end
    end

    // consecutive stalled-cycle watchdog run, saturating at MAX_STALL
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_run <= '0;
        end else if (!w_stalled) begin
            r_run <= '0;
        end else if (r_run != RUN_MAX) begin
            r_run <= r_run + RUN_W'(1);
        end
    end

    // sticky timeout flag; clear has priority over a new hit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_timeout <= 1'b0;
        end else if (bus.clr_i) begin
            r_timeout <= 1'b0;
        end else if (w_run_hit) begin
            r_timeout <= 1'b1;
        end
    end

    // stalled-cycle counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (bus.clr_i) begin
            r_stall_cnt <= '0;
        end else if (w_stalled) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    // flush counter, wraps naturally
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_flush_cnt <= '0;
        end else if (bus.clr_i) begin
            r_flush_cnt <= '0;
        end else if (w_flush_now) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign bus.stall_o     = w_stall;
    assign bus.flush_o     = w_flush_now;
    assign bus.stall_cnt_o = r_stall_cnt;
    assign bus.flush_cnt_o = r_flush_cnt;
    assign bus.timeout_o   = r_timeout;
endmodule

// File: tb/tb_riscv_stall_ctrl.sv
// tb/tb_riscv_stall_ctrl.sv - randomized and directed bench for riscv_stall_ctrl
module tb_riscv_stall_ctrl;
    localparam int MAXS  = 8;
    localparam int CW    = 4;
    localparam int SMOD  = 1 << CW;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    riscv_stall_ctrl_if #(.CNT_W(CW)) bus ();

    riscv_stall_ctrl #(.MAX_STALL(MAXS), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // reference state
    int   m_run  = 0;
    int   m_scnt = 0;
    int   m_fcnt = 0;
    bit   m_pend = 0;
    bit   m_to   = 0;

    int   e_stall;
    bit   e_adv;
    bit   e_flush;

    // expected combinational outputs from the priority rules
    always_comb begin
        e_adv   = !(bus.stallreq_mem_i || bus.stallreq_ex_i);
        e_flush = e_adv && (bus.br_taken_i || m_pend);
        e_stall = 0;
        if (bus.stallreq_mem_i)      e_stall = 15;
        else if (bus.stallreq_ex_i)  e_stall = 7;
        else if (e_flush)            e_stall = 0;
        else if (bus.stallreq_id_i)  e_stall = 3;
        else if (bus.stallreq_if_i)  e_stall = 1;
    end

    // reference state evolution
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_run  <= 0;
            m_scnt <= 0;
            m_fcnt <= 0;
            m_pend <= 0;
            m_to   <= 0;
        end else begin
            m_run  <= (e_stall != 0) ? ((m_run < MAXS) ? m_run + 1 : m_run) : 0;
            m_pend <= e_flush ? 1'b0 : (m_pend || (bus.br_taken_i && !e_adv));
            if (bus.clr_i) begin
                m_scnt <= 0;
                m_fcnt <= 0;
                m_to   <= 0;
            end else begin
                m_scnt <= (m_scnt + ((e_stall != 0) ? 1 : 0)) % SMOD;
                m_fcnt <= (m_fcnt + (e_flush ? 1 : 0)) % 65536;
                if (e_stall != 0 && m_run == MAXS - 1) m_to <= 1;
            end
        end
    end

    task automatic chk(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", nm, got, exp, $time);
        end
    endtask

    // per-cycle comparison against the reference
    always @(negedge clk) begin
        chk("stall_o",     int'(bus.stall_o),     e_stall);
        chk("flush_o",     int'(bus.flush_o),     int'(e_flush));
        chk("stall_cnt_o", int'(bus.stall_cnt_o), m_scnt);
        chk("flush_cnt_o", int'(bus.flush_cnt_o), m_fcnt);
        chk("timeout_o",   int'(bus.timeout_o),   int'(m_to));
    end

    task automatic setin(input bit f, input bit d, input bit e, input bit m,
                         input bit b, input bit c);
        bus.stallreq_if_i  = f;
        bus.stallreq_id_i  = d;
        bus.stallreq_ex_i  = e;
        bus.stallreq_mem_i = m;
        bus.br_taken_i     = b;
        bus.clr_i          = c;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        setin(0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_stall_cnt", int'(bus.stall_cnt_o), 0);
        chk("rst_flush_cnt", int'(bus.flush_cnt_o), 0);
        chk("rst_timeout",   int'(bus.timeout_o),   0);
        chk("rst_stall",     int'(bus.stall_o),     0);
        tick;
        rst = 1'b1;
        tick;

        // single requests
        setin(1, 0, 0, 0, 0, 0); @(negedge clk);
        chk("if_stall", int'(bus.stall_o), 1); chk("if_flush", int'(bus.flush_o), 0);
        tick; chk("if_cnt", int'(bus.stall_cnt_o), 1);
        setin(0, 1, 0, 0, 0, 0); @(negedge clk);
        chk("id_stall", int'(bus.stall_o), 3);
        tick; chk("id_cnt", int'(bus.stall_cnt_o), 2);
        setin(0, 0, 1, 0, 0, 0); @(negedge clk);
        chk("ex_stall", int'(bus.stall_o), 7);
        tick; chk("ex_cnt", int'(bus.stall_cnt_o), 3);
        setin(0, 0, 0, 1, 0, 0); @(negedge clk);
        chk("mem_stall", int'(bus.stall_o), 15);
        tick; chk("mem_cnt", int'(bus.stall_cnt_o), 4);

        // load-use together with taken branch: flush wins
        setin(0, 1, 0, 0, 1, 0); @(negedge clk);
        chk("idbr_stall", int'(bus.stall_o), 0); chk("idbr_flush", int'(bus.flush_o), 1);
        tick; chk("idbr_fcnt", int'(bus.flush_cnt_o), 1);

        // branch held across a MEM stall: one deferred flush
        for (int k = 0; k < 4; k++) begin
            setin(0, 0, 0, (k < 3), 1, 0); @(negedge clk);
            chk("defer_flush", int'(bus.flush_o), (k == 3) ? 1 : 0);
            tick;
        end
        setin(0, 0, 0, 0, 0, 0); @(negedge clk);
        chk("defer_after", int'(bus.flush_o), 0);
        chk("defer_fcnt", int'(bus.flush_cnt_o), 2);
        chk("defer_scnt", int'(bus.stall_cnt_o), 7);
        tick;

        // watchdog
        setin(0, 0, 0, 0, 0, 1); tick;
        chk("clr0_scnt", int'(bus.stall_cnt_o), 0);
        setin(0, 0, 1, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            tick; chk("wd_timeout", int'(bus.timeout_o), (k >= 8) ? 1 : 0);
        end
        setin(0, 0, 0, 0, 0, 0); tick; tick;
        chk("wd_sticky", int'(bus.timeout_o), 1);
        chk("wd_scnt", int'(bus.stall_cnt_o), 10);
        setin(0, 0, 0, 0, 0, 1); tick;
        chk("clr_timeout", int'(bus.timeout_o), 0);
        chk("clr_scnt", int'(bus.stall_cnt_o), 0);
        chk("clr_fcnt", int'(bus.flush_cnt_o), 0);

        // reset with a pending flush mid-stall
        setin(0, 0, 0, 1, 1, 0); tick;
        #2; rst = 1'b0; #1;
        chk("rstm_scnt", int'(bus.stall_cnt_o), 0);
        chk("rstm_timeout", int'(bus.timeout_o), 0);
        setin(0, 0, 0, 0, 0, 0);
        @(posedge clk); #1; rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("rstm_noflush", int'(bus.flush_o), 0); tick;
        end
        chk("rstm_fcnt", int'(bus.flush_cnt_o), 0);

        // stall counter wrap
        setin(1, 0, 0, 0, 0, 0);
        repeat (15) tick;
        chk("wrap_full", int'(bus.stall_cnt_o), 15);
        tick;
        chk("wrap_zero", int'(bus.stall_cnt_o), 0);
        setin(0, 0, 0, 0, 0, 0); tick;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 250) begin
                setin(0, 0, 1, 0, ($urandom_range(0, 1) == 1), 0);
                repeat (12) tick;
            end
            setin(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 39) == 0));
            if ($urandom_range(0, 499) == 0) begin
                #2; rst = 1'b0;
                @(posedge clk); #1; rst = 1'b1;
            end else begin
                tick;
            end
        end
        setin(0, 0, 0, 0, 0, 0);
        tick; tick;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
